// File: rtl/ppu_pkg.sv
// Shared PPU constants: state encodings, CPU register address and status bit positions.
package ppu_pkg;

   localparam logic [7:0]  PPU_ST_FRAME_START = 8'd1;
   localparam logic [7:0]  PPU_ST_VBLANK_WAIT = 8'd8;
   localparam logic [15:0] PPU_STATUS_ADDR    = 16'h2002;

   localparam int unsigned STATUS_BIT_VBL  = 7;
   localparam int unsigned STATUS_BIT_SPR0 = 6;
   localparam int unsigned STATUS_BIT_OVF  = 5;

   // Flags occupy the top num_flags bits; the rest comes from the open-bus latch.
   function automatic logic [7:0] pack_status(input logic [7:0] flags,
                                              input int unsigned num_flags,
                                              input logic [7:0] latch);
      logic [7:0] mask;
      mask = 8'hFF << (8 - num_flags);
      return ((flags << (8 - num_flags)) & mask) | (latch & ~mask);
   endfunction

endpackage

// File: rtl/ppu_status_flags_if.sv
// CPU-side view of the status register: address/read strobe in, live and snapshot data out.
interface ppu_status_flags_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_rd;
   logic [7:0]        status_live;
   logic [7:0]        status_rd_data;

   modport master (
      output cpu_addr, cpu_rd,
      input  status_live, status_rd_data
   );

   modport slave (
      input  cpu_addr, cpu_rd,
      output status_live, status_rd_data
   );
endinterface

// File: rtl/ppu_sticky_flag.sv
// One sticky status flag: frame clear beats set, set beats read clear.
module ppu_sticky_flag (
   input  logic clk,
   input  logic rst,
   input  logic frame_clr,
   input  logic set,
   input  logic rd_clr,
   output logic flag_q,
   output logic flag_d
);

   always_comb begin
      flag_d = flag_q;
      if (frame_clr) begin
         flag_d = 1'b0;
      end else if (set) begin
         flag_d = 1'b1;
      end else if (rd_clr) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q <= 1'b0;
      end else begin
         flag_q <= flag_d;
      end
   end

endmodule

// File: rtl/ppu_status_flags.sv
// PPU status register: sticky flags, read snapshot, vblank/read race suppression and NMI request.
module ppu_status_flags
   import ppu_pkg::*;
#(
   parameter int unsigned           NUM_FLAGS         = 3,
   parameter int unsigned           STATE_W           = 8,
   parameter logic [STATE_W-1:0]    FRAME_START_STATE = STATE_W'(PPU_ST_FRAME_START),
   parameter logic [STATE_W-1:0]    VBLANK_STATE      = STATE_W'(PPU_ST_VBLANK_WAIT),
   parameter int unsigned           ADDR_W            = 16,
   parameter logic [ADDR_W-1:0]     STATUS_ADDR       = ADDR_W'(PPU_STATUS_ADDR),
   parameter logic [NUM_FLAGS-1:0]  READ_CLR_MASK     = {1'b1, {(NUM_FLAGS-1){1'b0}}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STATE_W-1:0]   ppu_state,
   input  logic [NUM_FLAGS-2:0] flag_set,
   input  logic                 nmi_enable,
   input  logic [7:0]           bus_latch,
   ppu_status_flags_if.slave    cpu,
   output logic                 nmi_req
);

   localparam int unsigned VblIdx = NUM_FLAGS - 1;

   logic                 vbl_prev_q, rd_prev_q, suppress_q;
   logic                 suppress_d;
   logic [7:0]           rd_data_q;
   logic                 rd_hit, rd_start, in_vbl, vbl_entry, frame_start, race;
   logic [NUM_FLAGS-1:0] set_vec, clr_vec, flag_q, flag_d;

   always_comb begin
      rd_hit      = cpu.cpu_rd && (cpu.cpu_addr == STATUS_ADDR);
      rd_start    = rd_hit && !rd_prev_q;
      in_vbl      = (ppu_state == VBLANK_STATE);
      vbl_entry   = in_vbl && !vbl_prev_q;
      frame_start = (ppu_state == FRAME_START_STATE);
      race        = vbl_entry && rd_start;
   end

   for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
      if (i == VblIdx) begin : g_vbl
         // A read landing on the entry cycle hides this vblank entirely.
         assign set_vec[i] = vbl_entry && !race;
         assign clr_vec[i] = rd_start && (READ_CLR_MASK[i] || race);
      end else begin : g_ext
         assign set_vec[i] = flag_set[i];
         assign clr_vec[i] = rd_start && READ_CLR_MASK[i];
      end

      ppu_sticky_flag u_flag (
         .clk       (clk),
         .rst       (rst),
         .frame_clr (frame_start),
         .set       (set_vec[i]),
         .rd_clr    (clr_vec[i]),
         .flag_q    (flag_q[i]),
         .flag_d    (flag_d[i])
      );
   end

   always_comb begin
      suppress_d = suppress_q;
      if (frame_start) begin
         suppress_d = 1'b0;
      end else if (race) begin
         suppress_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vbl_prev_q <= 1'b0;
         rd_prev_q  <= 1'b0;
         suppress_q <= 1'b0;
         rd_data_q  <= 8'h00;
         nmi_req    <= 1'b0;
      end else begin
         vbl_prev_q <= in_vbl;
         rd_prev_q  <= rd_hit;
         suppress_q <= suppress_d;
         if (rd_start) begin
            rd_data_q <= pack_status(8'(flag_q), NUM_FLAGS, bus_latch);
         end
         nmi_req <= flag_d[VblIdx] && nmi_enable && !suppress_d;
      end
   end

   assign cpu.status_live    = pack_status(8'(flag_q), NUM_FLAGS, bus_latch);
   assign cpu.status_rd_data = rd_data_q;

endmodule

// File: tb/tb_ppu_status_flags.sv
// Directed bench for ppu_status_flags: default 3-flag instance plus a 4-flag, mask 4'b1001 variant.
module tb_ppu_status_flags;
   import ppu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default instance
   logic [7:0] st_a, latch_a;
   logic [1:0] fs_a;
   logic       en_a, nmi_a;
   ppu_status_flags_if #(.ADDR_W(16)) bus_a ();

   ppu_status_flags dut_a (
      .clk        (clk),
      .rst        (rst),
      .ppu_state  (st_a),
      .flag_set   (fs_a),
      .nmi_enable (en_a),
      .bus_latch  (latch_a),
      .cpu        (bus_a.slave),
      .nmi_req    (nmi_a)
   );

   // Four-flag instance
   logic [7:0] st_b, latch_b;
   logic [2:0] fs_b;
   logic       en_b, nmi_b;
   ppu_status_flags_if #(.ADDR_W(16)) bus_b ();

   ppu_status_flags #(
      .NUM_FLAGS     (4),
      .READ_CLR_MASK (4'b1001)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .ppu_state  (st_b),
      .flag_set   (fs_b),
      .nmi_enable (en_b),
      .bus_latch  (latch_b),
      .cpu        (bus_b.slave),
      .nmi_req    (nmi_b)
   );

   typedef struct {
      logic [7:0]  st;
      logic [1:0]  fs;
      logic [15:0] addr;
      logic        rd;
      logic        en;
      logic [7:0]  latch;
      logic [7:0]  live;
      logic [7:0]  rdd;
      logic        nmi;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] st, input logic [1:0] fs, input logic [15:0] addr,
                      input logic rd, input logic en, input logic [7:0] latch,
                      input logic [7:0] live, input logic [7:0] rdd, input logic nmi);
      vq.push_back('{st, fs, addr, rd, en, latch, live, rdd, nmi});
   endtask

   initial begin
      rst = 1'b1;
      st_a = 8'd0; fs_a = 2'b00; en_a = 1'b1; latch_a = 8'h1F;
      bus_a.cpu_addr = 16'h0000; bus_a.cpu_rd = 1'b0;
      st_b = 8'd0; fs_b = 3'b000; en_b = 1'b0; latch_b = 8'h00;
      bus_b.cpu_addr = 16'h0000; bus_b.cpu_rd = 1'b0;

      //  st    fs     addr      rd  en  latch  live   rdd    nmi
      // vblank entry, NMI, long read
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h1F, 8'h9F, 8'h00, 1);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h1F, 8'h9F, 8'h00, 1);
      add(8'd8, 2'b00, 16'h2002, 1, 1, 8'h1F, 8'h1F, 8'h9F, 0);
      add(8'd8, 2'b00, 16'h2002, 1, 1, 8'h1F, 8'h1F, 8'h9F, 0);
      add(8'd8, 2'b00, 16'h2002, 1, 1, 8'h1F, 8'h1F, 8'h9F, 0);
      add(8'd8, 2'b00, 16'h2002, 1, 1, 8'h1F, 8'h1F, 8'h9F, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h1F, 8'h1F, 8'h9F, 0);
      add(8'd1, 2'b00, 16'h0000, 0, 1, 8'h1F, 8'h1F, 8'h9F, 0);
      // non-vblank flags survive a read
      add(8'd2, 2'b01, 16'h0000, 0, 1, 8'h00, 8'h20, 8'h9F, 0);
      add(8'd2, 2'b10, 16'h0000, 0, 1, 8'h00, 8'h60, 8'h9F, 0);
      add(8'd2, 2'b00, 16'h2002, 1, 1, 8'h00, 8'h60, 8'h60, 0);
      add(8'd2, 2'b00, 16'h0000, 0, 1, 8'h00, 8'h60, 8'h60, 0);
      add(8'd1, 2'b00, 16'h0000, 0, 1, 8'h00, 8'h00, 8'h60, 0);
      // frame start beats set
      add(8'd1, 2'b01, 16'h0000, 0, 1, 8'h00, 8'h00, 8'h60, 0);
      // late NMI enable
      add(8'd2, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h00, 8'h60, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h80, 8'h60, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h00, 8'h80, 8'h60, 1);
      add(8'd8, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h80, 8'h60, 0);
      add(8'd1, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h00, 8'h60, 0);
      // wrong address is ignored
      add(8'd2, 2'b00, 16'h2003, 1, 1, 8'h0A, 8'h0A, 8'h60, 0);
      add(8'd2, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h0A, 8'h60, 0);
      // race: entry and read start together, suppressed until frame start
      add(8'd8, 2'b00, 16'h2002, 1, 1, 8'h0A, 8'h0A, 8'h0A, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h0A, 8'h0A, 0);
      add(8'd9, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h0A, 8'h0A, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h8A, 8'h0A, 0);
      add(8'd1, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h0A, 8'h0A, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h8A, 8'h0A, 1);
      add(8'd8, 2'b00, 16'h2002, 1, 1, 8'h0A, 8'h0A, 8'h8A, 0);
      add(8'd8, 2'b00, 16'h0000, 0, 1, 8'h0A, 8'h0A, 8'h8A, 0);

      tick();
      tick();
      check8("reset_live", bus_a.status_live, 8'h1F);
      check8("reset_rd_data", bus_a.status_rd_data, 8'h00);
      check8("reset_nmi", {7'b0, nmi_a}, 8'h00);
      check8("reset_b_live", bus_b.status_live, 8'h00);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         st_a = vq[i].st; fs_a = vq[i].fs; en_a = vq[i].en; latch_a = vq[i].latch;
         bus_a.cpu_addr = vq[i].addr; bus_a.cpu_rd = vq[i].rd;
         tick();
         check8($sformatf("vec%0d_live", i), bus_a.status_live, vq[i].live);
         check8($sformatf("vec%0d_rd_data", i), bus_a.status_rd_data, vq[i].rdd);
         check8($sformatf("vec%0d_nmi", i), {7'b0, nmi_a}, {7'b0, vq[i].nmi});
      end

      // Reset during a held read: the post-reset cycle is a fresh read start
      st_a = 8'd2; fs_a = 2'b00; en_a = 1'b1; latch_a = 8'h15;
      bus_a.cpu_addr = 16'h2002; bus_a.cpu_rd = 1'b1;
      rst = 1'b1;
      tick();
      check8("midrd_reset_rd_data", bus_a.status_rd_data, 8'h00);
      check8("midrd_reset_live", bus_a.status_live, 8'h15);
      rst = 1'b0;
      tick();
      check8("midrd_new_start", bus_a.status_rd_data, 8'h15);
      latch_a = 8'h03;
      tick();
      check8("midrd_no_resnap", bus_a.status_rd_data, 8'h15);
      check8("midrd_live", bus_a.status_live, 8'h03);
      bus_a.cpu_rd = 1'b0;

      // Four flags, mask 4'b1001: bit4 and vblank clear on read, bits 5-6 stay
      st_b = 8'd2; fs_b = 3'b111; latch_b = 8'h05;
      tick();
      check8("b_set_live", bus_b.status_live, 8'h75);
      fs_b = 3'b000;
      bus_b.cpu_addr = 16'h2002; bus_b.cpu_rd = 1'b1;
      tick();
      check8("b_rd1_data", bus_b.status_rd_data, 8'h75);
      check8("b_rd1_live", bus_b.status_live, 8'h65);
      bus_b.cpu_rd = 1'b0;
      st_b = 8'd8;
      tick();
      check8("b_vbl_live", bus_b.status_live, 8'hE5);
      check8("b_nmi_disabled", {7'b0, nmi_b}, 8'h00);
      bus_b.cpu_rd = 1'b1;
      tick();
      check8("b_rd2_data", bus_b.status_rd_data, 8'hE5);
      check8("b_rd2_live", bus_b.status_live, 8'h65);
      bus_b.cpu_rd = 1'b0;
      st_b = 8'd1;
      tick();
      check8("b_frame_clear", bus_b.status_live, 8'h05);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
